// File: rtl/l0_fill_controller_pkg.sv
// Shared definitions for the L0 refill engine: FSM state encoding and
// line-alignment helpers used to turn a fetch PC into a line address.
package l0_fill_controller_pkg;

    localparam int unsigned MAX_PC_SIZE = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FILL = 2'd3
    } fill_state_e;

    // Number of byte-offset bits inside a line (line size is a power of two).
    function automatic int unsigned line_off_bits(input int unsigned line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic logic [MAX_PC_SIZE-1:0] line_align(
        input logic [MAX_PC_SIZE-1:0] pc,
        input int unsigned            off_bits
    );
        logic [MAX_PC_SIZE-1:0] mask;
        mask = {MAX_PC_SIZE{1'b1}} << off_bits;
        return pc & mask;
    endfunction

endpackage

// File: rtl/l0_fill_controller.sv
// L0 refill engine: turns an L0 miss into a line read from L1I, writes the
// returned line into L0, and optionally chases it with a next-line prefetch.
module l0_fill_controller
    import l0_fill_controller_pkg::*;
#(
    parameter int unsigned LINE_SIZE_BYTES = 64,
    parameter int unsigned PC_SIZE         = 64,
    parameter bit          PREFETCH_EN     = 1'b1
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         miss_valid_in,
    input  logic [PC_SIZE-1:0]           miss_pc_in,
    input  logic                         flush_in,
    output logic                         l1_req_valid_out,
    input  logic                         l1_req_ready_in,
    output logic [PC_SIZE-1:0]           l1_req_addr_out,
    input  logic                         l1_resp_valid_in,
    input  logic [LINE_SIZE_BYTES*8-1:0] l1_resp_data_in,
    output logic                         l0_fill_valid_out,
    output logic [PC_SIZE-1:0]           l0_fill_pc_out,
    output logic [LINE_SIZE_BYTES*8-1:0] l0_fill_data_out,
    output logic                         busy_out
);

    localparam int unsigned OFF       = line_off_bits(LINE_SIZE_BYTES);
    localparam int unsigned LINE_BITS = LINE_SIZE_BYTES * 8;
    localparam logic [PC_SIZE-1:0] LINE_STRIDE = PC_SIZE'(LINE_SIZE_BYTES);

    fill_state_e          state_q, state_d;
    logic [PC_SIZE-1:0]   addr_q, addr_d;
    logic [LINE_BITS-1:0] data_q, data_d;
    logic                 squash_q, squash_d;
    logic                 is_pf_q, is_pf_d;

    logic [PC_SIZE-1:0]   miss_line_s;
    logic [PC_SIZE-1:0]   next_line_s;
    logic                 next_wraps_s;

    // Line addresses derived from the incoming miss and from the current line.
    always_comb begin
        miss_line_s  = PC_SIZE'(line_align(MAX_PC_SIZE'(miss_pc_in), OFF));
        next_line_s  = addr_q + LINE_STRIDE;
        next_wraps_s = (next_line_s == {PC_SIZE{1'b0}});
    end

    // Next-state and datapath update for the refill sequence.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        squash_d = squash_q;
        is_pf_d  = is_pf_q;
        case (state_q)
            IDLE: begin
                if (miss_valid_in && !flush_in) begin
                    addr_d   = miss_line_s;
                    is_pf_d  = 1'b0;
                    squash_d = 1'b0;
                    state_d  = REQ;
                end else begin
                    state_d  = IDLE;
                end
            end
            REQ: begin
                // A request already presented must complete; a flush only marks
                // its response for discard.
                if (flush_in) begin
                    squash_d = 1'b1;
                end else begin
                    squash_d = squash_q;
                end
                if (l1_req_ready_in) begin
                    state_d = WAIT;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                if (l1_resp_valid_in) begin
                    data_d   = l1_resp_data_in;
                    squash_d = 1'b0;
                    if (squash_q || flush_in) begin
                        state_d = IDLE;
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            FILL: begin
                if (flush_in) begin
                    state_d = IDLE;
                end else if (miss_valid_in && (miss_line_s != addr_q)) begin
                    addr_d  = miss_line_s;
                    is_pf_d = 1'b0;
                    state_d = REQ;
                end else if (PREFETCH_EN && !is_pf_q && !next_wraps_s) begin
                    addr_d  = next_line_s;
                    is_pf_d = 1'b1;
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            addr_q   <= {PC_SIZE{1'b0}};
            data_q   <= {LINE_BITS{1'b0}};
            squash_q <= 1'b0;
            is_pf_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            squash_q <= squash_d;
            is_pf_q  <= is_pf_d;
        end
    end

    assign l1_req_valid_out  = (state_q == REQ);
    assign l1_req_addr_out   = addr_q;
    assign l0_fill_valid_out = (state_q == FILL);
    assign l0_fill_pc_out    = addr_q;
    assign l0_fill_data_out  = data_q;
    assign busy_out          = (state_q != IDLE);

endmodule

// File: tb/tb_l0_fill_controller.sv
// Directed and randomized bench for l0_fill_controller, checked against a
// transaction-level model of the refill behaviour.
module tb_l0_fill_controller;

    localparam int unsigned PCW = 64;
    localparam int unsigned DW  = 512;

    logic           clk = 1'b0;
    logic           rst;
    logic           miss_v;
    logic [PCW-1:0] miss_pc;
    logic           flush;
    logic           ready;
    logic           resp_v;
    logic [DW-1:0]  resp_data;

    logic           a_req_v, a_fill_v, a_busy;
    logic [PCW-1:0] a_req_addr, a_fill_pc;
    logic [DW-1:0]  a_fill_data;
    logic           b_req_v, b_fill_v, b_busy;
    logic [PCW-1:0] b_req_addr, b_fill_pc;
    logic [DW-1:0]  b_fill_data;

    int checks = 0;
    int errors = 0;

    // Transaction-level model of the prefetching instance.
    bit             m_txn, m_acc, m_cancel, m_pf;
    logic [PCW-1:0] m_addr;
    bit             m_fill, m_fill_pf;
    logic [PCW-1:0] m_fill_addr;
    logic [DW-1:0]  m_fill_data;

    logic [DW-1:0]  d_line;
    int             cd;

    always #5 clk = ~clk;

    l0_fill_controller #(.LINE_SIZE_BYTES(64), .PC_SIZE(64), .PREFETCH_EN(1'b1)) dut_a (
        .clk_in(clk), .rst_in(rst), .miss_valid_in(miss_v), .miss_pc_in(miss_pc),
        .flush_in(flush), .l1_req_valid_out(a_req_v), .l1_req_ready_in(ready),
        .l1_req_addr_out(a_req_addr), .l1_resp_valid_in(resp_v), .l1_resp_data_in(resp_data),
        .l0_fill_valid_out(a_fill_v), .l0_fill_pc_out(a_fill_pc),
        .l0_fill_data_out(a_fill_data), .busy_out(a_busy)
    );

    l0_fill_controller #(.LINE_SIZE_BYTES(64), .PC_SIZE(64), .PREFETCH_EN(1'b0)) dut_b (
        .clk_in(clk), .rst_in(rst), .miss_valid_in(miss_v), .miss_pc_in(miss_pc),
        .flush_in(flush), .l1_req_valid_out(b_req_v), .l1_req_ready_in(ready),
        .l1_req_addr_out(b_req_addr), .l1_resp_valid_in(resp_v), .l1_resp_data_in(resp_data),
        .l0_fill_valid_out(b_fill_v), .l0_fill_pc_out(b_fill_pc),
        .l0_fill_data_out(b_fill_data), .busy_out(b_busy)
    );

    function automatic logic [PCW-1:0] line_of(input logic [PCW-1:0] pc);
        return pc - (pc % 64'd64);
    endfunction

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [PCW-1:0] pick_pc();
        logic [PCW-1:0] p;
        case ($urandom_range(0, 4))
            0: p = 64'h1234;
            1: p = 64'h1240 + 64'($urandom_range(0, 63));
            2: p = {32'h0, $urandom};
            3: p = 64'hFFFF_FFFF_FFFF_FFC5;
            default: p = {$urandom, $urandom};
        endcase
        return p;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_txn(input logic [PCW-1:0] addr, input bit pf);
        m_txn    = 1'b1;
        m_acc    = 1'b0;
        m_cancel = 1'b0;
        m_pf     = pf;
        m_addr   = addr;
    endtask

    task automatic model_clear();
        m_txn = 1'b0; m_acc = 1'b0; m_cancel = 1'b0; m_pf = 1'b0;
        m_fill = 1'b0; m_fill_pf = 1'b0;
        m_addr = '0; m_fill_addr = '0; m_fill_data = '0;
    endtask

    // Compare instance A with the model, advance the model with the inputs
    // currently driven, then move to just after the next rising edge.
    task automatic tick();
        chk("req_valid", a_req_v, m_txn && !m_acc);
        if (m_txn && !m_acc) chk("req_addr", a_req_addr, m_addr);
        chk("fill_valid", a_fill_v, m_fill);
        if (m_fill) begin
            chk("fill_pc", a_fill_pc, m_fill_addr);
            chk("fill_data", a_fill_data, m_fill_data);
        end
        chk("busy", a_busy, m_txn || m_fill);

        if (rst) begin
            model_clear();
        end else if (m_fill) begin
            m_fill = 1'b0;
            if (!flush) begin
                if (miss_v && line_of(miss_pc) != m_fill_addr)
                    start_txn(line_of(miss_pc), 1'b0);
                else if (!m_fill_pf && (m_fill_addr + 64'd64) != 64'd0)
                    start_txn(m_fill_addr + 64'd64, 1'b1);
            end
        end else if (m_txn && !m_acc) begin
            if (flush) m_cancel = 1'b1;
            if (ready) m_acc = 1'b1;
        end else if (m_txn) begin
            if (flush) m_cancel = 1'b1;
            if (resp_v) begin
                m_txn = 1'b0;
                if (!m_cancel) begin
                    m_fill      = 1'b1;
                    m_fill_addr = m_addr;
                    m_fill_data = resp_data;
                    m_fill_pf   = m_pf;
                end
            end
        end else if (miss_v && !flush) begin
            start_txn(line_of(miss_pc), 1'b0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; miss_v = 1'b0; miss_pc = '0; flush = 1'b0;
        ready = 1'b0; resp_v = 1'b0; resp_data = '0; cd = 0;
        model_clear();
        @(posedge clk);
        #1;
        tick();
        rst = 1'b0;

        // Reset in the middle of WAIT, then a stray response.
        miss_v = 1'b1; miss_pc = 64'h1234; tick();
        ready = 1'b1; tick();
        ready = 1'b0; miss_v = 1'b0; tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("rst_req_valid", a_req_v, 1'b0);
        chk("rst_req_addr", a_req_addr, 64'h0);
        chk("rst_fill_valid", a_fill_v, 1'b0);
        chk("rst_fill_pc", a_fill_pc, 64'h0);
        chk("rst_fill_data", a_fill_data, {DW{1'b0}});
        chk("rst_busy", a_busy, 1'b0);
        resp_v = 1'b1; resp_data = rand_line(); tick();
        resp_v = 1'b0; tick();
        chk("rst_no_fill", a_fill_v, 1'b0);

        // Demand miss, fill three cycles after acceptance, then prefetch.
        miss_v = 1'b1; miss_pc = 64'h1234; ready = 1'b1; tick();
        chk("t2_req_addr", a_req_addr, 64'h1200);
        tick();
        miss_v = 1'b0; tick();
        tick();
        d_line = rand_line(); resp_v = 1'b1; resp_data = d_line; tick();
        resp_v = 1'b0;
        chk("t2_fill_valid", a_fill_v, 1'b1);
        chk("t2_fill_pc", a_fill_pc, 64'h1200);
        chk("t2_fill_data", a_fill_data, d_line);
        tick();
        chk("t2_pf_valid", a_req_v, 1'b1);
        chk("t2_pf_addr", a_req_addr, 64'h1240);

        // Demand miss while the prefetch is outstanding.
        miss_v = 1'b1; miss_pc = 64'h8000; tick();
        resp_v = 1'b1; resp_data = rand_line(); tick();
        resp_v = 1'b0;
        chk("t5_pf_fill_pc", a_fill_pc, 64'h1240);
        tick();
        chk("t5_demand_addr", a_req_addr, 64'h8000);
        tick();
        miss_v = 1'b0;
        resp_v = 1'b1; resp_data = rand_line(); tick();
        resp_v = 1'b0;
        chk("t5_demand_fill", a_fill_pc, 64'h8000);
        tick();
        chk("t5_pf2_addr", a_req_addr, 64'h8040);
        tick();
        resp_v = 1'b1; resp_data = rand_line(); tick();
        resp_v = 1'b0; tick();
        chk("t5_pf_no_chain", a_busy, 1'b0);

        // Back-pressure: ready low for five cycles.
        ready = 1'b0; miss_v = 1'b1; miss_pc = 64'h1234; tick();
        miss_v = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold_valid", a_req_v, 1'b1);
            chk("t3_hold_addr", a_req_addr, 64'h1200);
            tick();
        end
        ready = 1'b1; tick();
        chk("t3_wait_valid", a_req_v, 1'b0);
        chk("t3_wait_busy", a_busy, 1'b1);

        // Flush together with the response: no fill, no prefetch.
        flush = 1'b1; resp_v = 1'b1; resp_data = rand_line(); tick();
        flush = 1'b0; resp_v = 1'b0;
        chk("t4_no_fill", a_fill_v, 1'b0);
        chk("t4_idle", a_busy, 1'b0);
        tick();
        chk("t4_no_pf", a_req_v, 1'b0);

        // Top line: no wrapped prefetch.
        miss_v = 1'b1; miss_pc = 64'hFFFF_FFFF_FFFF_FFC5; tick();
        chk("t6_req_addr", a_req_addr, 64'hFFFF_FFFF_FFFF_FFC0);
        miss_v = 1'b0; tick();
        resp_v = 1'b1; resp_data = rand_line(); tick();
        resp_v = 1'b0;
        chk("t6_fill_pc", a_fill_pc, 64'hFFFF_FFFF_FFFF_FFC0);
        tick();
        chk("t6_no_wrap", a_req_v, 1'b0);
        chk("t6_idle", a_busy, 1'b0);

        // Instance without prefetch returns to IDLE after the fill.
        rst = 1'b1; tick();
        rst = 1'b0;
        miss_v = 1'b1; miss_pc = 64'h1234; ready = 1'b1; tick();
        chk("nopf_req_addr", b_req_addr, 64'h1200);
        tick();
        miss_v = 1'b0;
        d_line = rand_line(); resp_v = 1'b1; resp_data = d_line; tick();
        resp_v = 1'b0;
        chk("nopf_fill_valid", b_fill_v, 1'b1);
        chk("nopf_fill_data", b_fill_data, d_line);
        tick();
        chk("nopf_req_valid", b_req_v, 1'b0);
        chk("nopf_busy", b_busy, 1'b0);

        // Randomized traffic with the bench acting as L1I.
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 149) == 0);
            miss_v  = ($urandom_range(0, 2) != 0);
            miss_pc = pick_pc();
            ready   = $urandom_range(0, 1) != 0;
            resp_v  = 1'b0;
            flush   = 1'b0;
            if (m_txn && m_acc) begin
                if (cd == 0) begin
                    resp_v    = 1'b1;
                    resp_data = rand_line();
                    flush     = ($urandom_range(0, 3) == 0);
                end else begin
                    cd--;
                end
            end else begin
                flush = ($urandom_range(0, 11) == 0);
                cd    = $urandom_range(0, 3);
            end
            tick();
        end

        rst = 1'b0; miss_v = 1'b0; flush = 1'b0; ready = 1'b0; resp_v = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
